spi_slave_engine: RTL and testbench

Slave-side SPI shift engine; the counterpart of the master serial-clock generator when the peripheral is strapped to slave mode. Oversamples an external SCLK, SS_N and MOSI in the system clock domain and decodes CPOL/CPHA edges. Shifts a received byte in from MOSI and a transmit byte out on MISO. Presents bytes to the SoC bus through a one-entry TX holding register and a one-cycle RX strobe.

---
 rtl/spi_slave_engine_pkg.sv | 16 +
 rtl/spi_sync.sv | 22 ++
 rtl/spi_slave_engine.sv | 151 +++++++++++++++
 tb/tb_spi_slave_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_engine_pkg.sv
// Shared SPI slave definitions: mode encodings {cpol,cpha}, default frame width, select FSM states.
package spi_slave_engine_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; resets to the pin's idle level.
// Latency STAGES clk cycles, no backpressure.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain <= {STAGES{RST_VAL}};
      else      chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave shift engine: oversampled SCLK/SS_N/MOSI, CPOL/CPHA decode, one-entry TX holding register.
// Pin-to-action latency SYNC_STAGES+1 clk; TX side uses valid/ready, RX side is a one-cycle strobe.
module spi_slave_engine
   import spi_slave_engine_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun
);

   localparam int CNT_W = $clog2(DATA_W);

   logic              sclk_s, ss_n_s, mosi_s, sclk_d;
   logic              sel, lead, trail, sample_edge, shift_edge;
   logic              sel_assert, sel_deassert, active;
   state_t            state, state_nxt;
   logic [DATA_W-1:0] tx_sr, rx_sr, hold_dat, load_dat, rx_next;
   logic              hold_full, wr, load, load_empty, byte_done;
   logic [CNT_W-1:0]  bit_cnt;
   logic              reload_pend;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
      .clk(clk), .rst(rst), .d(ss_n), .q(ss_n_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sclk_d <= 1'b0;
      else      sclk_d <= sclk_s;
   end

   assign sel         = ~ss_n_s;
   assign lead        = (sclk_s != cpol) && (sclk_d == cpol);
   assign trail       = (sclk_s == cpol) && (sclk_d != cpol);
   assign sample_edge = cpha ? trail : lead;
   assign shift_edge  = cpha ? lead  : trail;

   // The state register doubles as the select edge detector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      sel_assert   = 1'b0;
      sel_deassert = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel) begin
               state_nxt  = ST_ACTIVE;
               sel_assert = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!sel) begin
               state_nxt    = ST_IDLE;
               sel_deassert = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign active     = (state == ST_ACTIVE) && sel;
   assign wr         = tx_valid && !hold_full;
   assign load       = sel_assert || (active && shift_edge && reload_pend);
   // Empty register at load time: a same-cycle write bypasses, otherwise send zeros.
   assign load_empty = load && !hold_full && !wr;
   assign load_dat   = hold_full ? hold_dat : (wr ? tx_data : '0);
   assign byte_done  = active && sample_edge && (bit_cnt == CNT_W'(DATA_W-1));
   assign rx_next    = {rx_sr[DATA_W-2:0], mosi_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         hold_dat  <= '0;
      end else if (load && hold_full) begin
         hold_full <= 1'b0;
      end else if (wr && !load) begin
         hold_dat  <= tx_data;
         hold_full <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_sr <= '0;
      end else if (load) begin
         tx_sr <= load_dat;
      end else if (active && shift_edge && bit_cnt != '0) begin
         tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt     <= '0;
         reload_pend <= 1'b0;
         rx_sr       <= '0;
         rx_data     <= '0;
      end else if (sel_assert || sel_deassert) begin
         bit_cnt     <= '0;
         reload_pend <= 1'b0;
      end else if (active) begin
         if (sample_edge) begin
            rx_sr <= rx_next;
            if (byte_done) begin
               bit_cnt     <= '0;
               reload_pend <= 1'b1;
               rx_data     <= rx_next;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
         if (shift_edge && reload_pend) reload_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
      end else begin
         rx_valid <= byte_done;
         underrun <= load_empty;
      end
   end

   assign miso     = tx_sr[DATA_W-1];
   assign miso_oe  = sel;
   assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Bench acting as SPI master: table-driven single frames, random frames, and multi-cycle corner sequences.
module tb_spi_slave_engine;
   import spi_slave_engine_pkg::*;

   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpol, cpha, sclk, ss_n, mosi;
   logic       miso, miso_oe, tx_ready, rx_valid, underrun, tx_valid;
   logic [7:0] tx_data, rx_data;

   int vectors = 0;
   int miscompares = 0;
   int urn_cnt = 0;
   int wide_pulses = 0;
   logic rxv_prev = 1'b0, urn_prev = 1'b0;
   logic [7:0] rxq[$];

   typedef struct {
      logic [1:0] mode;
      logic       tx_en;
      logic [7:0] tx_byte;
      logic [7:0] mo_byte;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
      int         exp_urn;
   } vec_t;

   spi_slave_engine #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
      .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .underrun(underrun));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         if (rx_valid) rxq.push_back(rx_data);
         if (underrun) urn_cnt++;
         if ((rx_valid && rxv_prev) || (underrun && urn_prev)) wide_pulses++;
      end
      rxv_prev = rx_valid;
      urn_prev = underrun;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   // Reference: MISO carries the written byte (zeros on underrun); RX echoes MOSI.
   // Underruns: one at select with no byte written, plus one for the reload
   // that CPHA=0 performs on the final trailing edge of every byte.
   function automatic vec_t model(input logic [1:0] m, input logic te,
                                  input logic [7:0] tb, input logic [7:0] mb);
      vec_t v;
      v.mode = m; v.tx_en = te; v.tx_byte = tb; v.mo_byte = mb;
      v.exp_miso = te ? tb : 8'h00;
      v.exp_rx   = mb;
      v.exp_urn  = (te ? 0 : 1) + (m[0] ? 0 : 1);
      return v;
   endfunction

   task automatic write_tx(input logic [7:0] b);
      int cyc;
      cyc = 0;
      while (!tx_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("tx_ready_wait", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic sel_begin(input logic [1:0] m);
      cpol = m[1];
      cpha = m[0];
      sclk = m[1];
      repeat (6) @(negedge clk);
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic sel_end();
      half();
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic xfer_bits(input logic [1:0] m, input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi);
      logic cp;
      cp = m[1];
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!m[0]) begin
            mosi = mo[i]; half();
            mi[i] = miso; sclk = ~cp; half();
            sclk = cp;
         end else begin
            half(); sclk = ~cp; mosi = mo[i];
            half(); mi[i] = miso; sclk = cp;
         end
      end
      half();
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int rx0, u0;
      logic [7:0] mi;
      rx0 = rxq.size();
      u0  = urn_cnt;
      if (v.tx_en) write_tx(v.tx_byte);
      sel_begin(v.mode);
      check({tag, "_tx_ready"}, tx_ready, 1);
      check({tag, "_oe_on"}, miso_oe, 1);
      xfer_bits(v.mode, v.mo_byte, 8, mi);
      sel_end();
      check({tag, "_oe_off"}, miso_oe, 0);
      check({tag, "_miso"}, mi, v.exp_miso);
      check({tag, "_rx_cnt"}, rxq.size() - rx0, 1);
      check({tag, "_rx_data"}, rx_data, v.exp_rx);
      check({tag, "_underrun"}, urn_cnt - u0, v.exp_urn);
   endtask

   initial begin
      vec_t tbl[6];
      vec_t v;
      int rx0, u0;
      logic [7:0] mi;
      logic [31:0] r0, r1;

      tbl[0] = model(MODE0, 1'b1, 8'hA5, 8'h3C);
      tbl[1] = model(MODE1, 1'b1, 8'h5A, 8'h5A);
      tbl[2] = model(MODE2, 1'b1, 8'h5A, 8'h5A);
      tbl[3] = model(MODE0, 1'b0, 8'h00, 8'hC7);
      tbl[4] = model(MODE3, 1'b1, 8'h3E, 8'h81);
      tbl[5] = model(MODE1, 1'b0, 8'h00, 8'h10);

      rst = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_underrun", underrun, 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Partial frame aborted after 5 bits, then a full frame.
      rx0 = rxq.size();
      u0  = urn_cnt;
      sel_begin(MODE0);
      xfer_bits(MODE0, 8'hE8, 5, mi);
      sel_end();
      check("partial_rx_cnt", rxq.size() - rx0, 0);
      check("partial_oe_off", miso_oe, 0);
      check("partial_underrun", urn_cnt - u0, 1);
      run_vec(model(MODE0, 1'b0, 8'h00, 8'h99), "after_partial");

      // Reset asserted mid-frame.
      write_tx(8'h55);
      sel_begin(MODE0);
      xfer_bits(MODE0, 8'hFF, 4, mi);
      rst = 1'b0;
      #1;
      check("midrst_miso", miso, 0);
      check("midrst_miso_oe", miso_oe, 0);
      check("midrst_rx_data", rx_data, 0);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_tx_ready", tx_ready, 1);
      check("midrst_underrun", underrun, 0);
      ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      run_vec(model(MODE0, 1'b1, 8'hC3, 8'h6E), "post_rst");

      for (int i = 0; i < 12; i++) begin
         v = model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom));
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Mode 3, two bytes in one select window, second byte written after tx_ready.
      rx0 = rxq.size();
      u0  = urn_cnt;
      write_tx(8'h81);
      sel_begin(MODE3);
      check("m3_tx_ready", tx_ready, 1);
      write_tx(8'h7E);
      xfer_bits(MODE3, 8'hF0, 8, mi);
      check("m3_miso0", mi, 8'h81);
      xfer_bits(MODE3, 8'h0F, 8, mi);
      check("m3_miso1", mi, 8'h7E);
      sel_end();
      check("m3_rx_cnt", rxq.size() - rx0, 2);
      r0 = (rxq.size() > rx0)     ? 32'(rxq[rx0])     : 32'hDEAD;
      r1 = (rxq.size() > rx0 + 1) ? 32'(rxq[rx0 + 1]) : 32'hDEAD;
      check("m3_rx0", r0, 8'hF0);
      check("m3_rx1", r1, 8'h0F);
      check("m3_underrun", urn_cnt - u0, 0);

      check("strobe_width", wide_pulses, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
